// File: rtl/cpm_reg_p2s.sv
// Parallel-to-serial drain for CPM capture registers: takes one DW-bit word on a
// valid/ready input and emits it as DW/SW beats of SW bits, flagging the last beat.
module cpm_reg_p2s #(
  parameter int DW        = 32,
  parameter int SW        = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Clear,
  input  logic          InVld,
  output logic          InRdy,
  input  logic [DW-1:0] DataIn,
  output logic          OutVld,
  input  logic          OutRdy,
  output logic [SW-1:0] DataOut,
  output logic          OutLast,
  output logic          Busy
);

  localparam int NBEAT = DW / SW;
  localparam int CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shreg_q, shreg_d;

  logic busy, beat_last, out_hs, in_rdy, accept;

  always_comb begin
    busy      = (state_q == ST_SHIFT);
    beat_last = (cnt_q == LAST_BEAT);
    out_hs    = busy & OutRdy;
    // The input reopens on the final beat handshake so words stream without a bubble.
    in_rdy    = ~Rst & ~Clear & (~busy | (out_hs & beat_last));
    accept    = InVld & in_rdy;

    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;

    if (Clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      shreg_d = DataIn;
    end else if (out_hs) begin
      shreg_d = (LSB_FIRST != 0) ? (shreg_q >> SW) : (shreg_q << SW);
      if (beat_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    InRdy   = in_rdy;
    Busy    = busy;
    OutVld  = busy;
    OutLast = busy & beat_last;
    DataOut = (LSB_FIRST != 0) ? shreg_q[SW-1:0] : shreg_q[DW-1:DW-SW];
  end

endmodule
